// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX FIFO push port between NUM_REQ byte
// streams. Round-robin arbitration with message locking: a grant is held
// until the owner's end-of-message byte or until MAX_BURST bytes have been
// written, so bytes from different sources never interleave within a burst.
//
// Optional feature: define UART_ARB_IDLE_TIMEOUT_EN to release a grant whose
// owner holds valid low for IDLE_TIMEOUT consecutive cycles. Without it, an
// idle owner keeps the grant until it sends a last byte or hits MAX_BURST.

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,   // 2..8
  parameter int MAX_BURST    = 16,  // 1..255
  parameter int IDLE_TIMEOUT = 32   // 1..255, timeout build only
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic                 fifo_full_i,
  output logic                 fifo_wr_en_o,
  output logic [7:0]           fifo_wr_data_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(NUM_REQ);

  // Burst counter value seen on the transfer that completes the burst.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;    // index of the most recently released owner
  logic [IW-1:0]   owner;   // binary index of the current grant
  logic [7:0]      count;   // bytes written under the current grant

  logic [IW-1:0]   pick;
  logic            pick_valid;

  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            fire;
  logic            release_msg;
  logic            release_idle;
  logic            release_now;

  // Lane of the current owner, selected by its binary index.
  assign own_valid = req_valid_i[owner];
  assign own_last  = req_last_i[owner];
  assign own_data  = req_data_i[{owner, 3'b000} +: 8];

  // A byte moves only while granted, the owner offers one and the FIFO has room.
  assign fire = busy_o & own_valid & ~fifo_full_i;

  // Release after the last byte of a message or the byte that fills the burst.
  assign release_msg = fire & (own_last | (count == BURST_LAST));

`ifdef UART_ARB_IDLE_TIMEOUT_EN
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  logic [7:0] idle_cnt;     // consecutive XFER cycles with owner valid low

  // The cycle that would bring the idle count to IDLE_TIMEOUT releases the
  // grant; valid is low there, so no byte is written in that cycle.
  assign release_idle = busy_o & ~own_valid & (idle_cnt == IDLE_LAST);
`else
  // Parameter kept for a uniform interface; it has no effect in this build.
  logic [7:0] unused_idle_timeout;
  assign unused_idle_timeout = 8'(IDLE_TIMEOUT);
  assign release_idle        = 1'b0;
`endif

  assign release_now = release_msg | release_idle;

  // Round-robin search: first valid requester at last+1, last+2, ... (mod NUM_REQ).
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    logic [IW-1:0] cand;
    pick       = last;
    pick_valid = 1'b0;
    cand       = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last) + i) % NUM_REQ);
      if (!pick_valid && req_valid_i[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Zero-latency pass-through from the owner's lane to the FIFO push port.
  always_comb begin
    req_ready_o    = '0;
    fifo_wr_en_o   = 1'b0;
    fifo_wr_data_o = 8'h00;
    if (busy_o) begin
      req_ready_o[owner] = ~fifo_full_i;
      fifo_wr_en_o       = fire;
      if (fire) fifo_wr_data_o = own_data;
    end
  end

  // Arbitration FSM: grant selection, burst counting and release; the grant
  // and busy outputs are registered here. Asynchronous reset clears busy_o at
  // once, which also silences every pass-through output in the reset cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      grant_o <= '0;
      busy_o  <= 1'b0;
      last    <= IW'(NUM_REQ - 1);
      owner   <= '0;
      count   <= 8'h00;
`ifdef UART_ARB_IDLE_TIMEOUT_EN
      idle_cnt <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= XFER;
            busy_o  <= 1'b1;
            grant_o <= NUM_REQ'(1) << pick;
            owner   <= pick;
            count   <= 8'h00;
`ifdef UART_ARB_IDLE_TIMEOUT_EN
            idle_cnt <= 8'h00;
`endif
          end
        end
        XFER: begin
          if (fire) count <= count + 8'h01;
`ifdef UART_ARB_IDLE_TIMEOUT_EN
          if (own_valid) idle_cnt <= 8'h00;
          else           idle_cnt <= idle_cnt + 8'h01;
`endif
          if (release_now) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            grant_o <= '0;
            last    <= owner;
          end
        end
        default: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          grant_o <= '0;
        end
      endcase
    end
  end

endmodule
